// File: rtl/timing_seq_counter_pkg.sv
// ---------------------------------------------------------------------------
// timing_seq_counter_pkg
// Shared control definitions for the timing-sequence counter.
//   - default WIDTH/MODULUS for the basic computer (4-bit count, 16 states)
//   - index names T0..T15 for the control timing vector
//   - the per-edge command encoding used by the counter
//   - a helper that counts how many command inputs are asserted together
// No ports (package).
// ---------------------------------------------------------------------------
package timing_seq_counter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 16;

    // Control timing names; t[T<n>] is high while seq == n.
    localparam int T0  = 0;
    localparam int T1  = 1;
    localparam int T2  = 2;
    localparam int T3  = 3;
    localparam int T4  = 4;
    localparam int T5  = 5;
    localparam int T6  = 6;
    localparam int T7  = 7;
    localparam int T8  = 8;
    localparam int T9  = 9;
    localparam int T10 = 10;
    localparam int T11 = 11;
    localparam int T12 = 12;
    localparam int T13 = 13;
    localparam int T14 = 14;
    localparam int T15 = 15;

    // What the counter does on a given falling edge, after priority resolution.
    typedef enum logic [2:0] {
        CMD_HOLD   = 3'd0,
        CMD_INC    = 3'd1,
        CMD_WRAP   = 3'd2,
        CMD_LOAD   = 3'd3,
        CMD_REJECT = 3'd4,
        CMD_CLEAR  = 3'd5
    } seq_cmd_e;

    function automatic logic [1:0] active_count(input logic inc, input logic clr,
                                                input logic ld);
        return {1'b0, inc} + {1'b0, clr} + {1'b0, ld};
    endfunction

endpackage

// File: rtl/timing_seq_counter_if.sv
// ---------------------------------------------------------------------------
// timing_seq_counter_if
// Command/status bundle of the timing-sequence counter.
// Parameters: WIDTH (count width), MODULUS (count length).
// Signals:
//   inc, clr, ld, ld_val   commands from the controller (master -> slave)
//   seq                    current count
//   t                      one-hot timing vector, t[i] = (seq == i)
//   tc                     terminal count level (seq == MODULUS-1)
//   wrap                   one-cycle pulse after a MODULUS-1 -> 0 increment
//   err                    sticky conflict flag (0 unless SEQ_CONFLICT_CHECK_EN)
// Modports: master (controller side), slave (counter side).
// ---------------------------------------------------------------------------
interface timing_seq_counter_if
    import timing_seq_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
);

    logic               inc;
    logic               clr;
    logic               ld;
    logic [WIDTH-1:0]   ld_val;
    logic [WIDTH-1:0]   seq;
    logic [MODULUS-1:0] t;
    logic               tc;
    logic               wrap;
    logic               err;

    modport master (
        output inc, clr, ld, ld_val,
        input  seq, t, tc, wrap, err
    );

    modport slave (
        input  inc, clr, ld, ld_val,
        output seq, t, tc, wrap, err
    );

endinterface

// File: rtl/timing_seq_counter_dec.sv
// ---------------------------------------------------------------------------
// seq_onehot_dec
// Binary-to-one-hot decoder for the timing vector.
// Parameters: WIDTH (input width), MODULUS (number of outputs).
// Ports:
//   seq  in  WIDTH    binary count, always < MODULUS
//   t    out MODULUS  t[i] = 1 iff seq == i
// ---------------------------------------------------------------------------
module seq_onehot_dec
    import timing_seq_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic [WIDTH-1:0]   seq,
    output logic [MODULUS-1:0] t
);

    // Compare per output rather than shifting, so a non-power-of-two MODULUS
    // never indexes past the top of t.
    always_comb begin
        t = '0;
        for (int i = 0; i < MODULUS; i++) begin
            t[i] = (seq == WIDTH'(i));
        end
    end

endmodule

// File: rtl/timing_seq_counter.sv
// ---------------------------------------------------------------------------
// timing_seq_counter
// Parametrised timing-sequence counter (generalised T-counter). Counts
// 0..MODULUS-1 and wraps, with synchronous clear, parallel load and hold.
// All state changes on the falling edge of clk; reset is asynchronous,
// active-high. Priority per edge: clr > ld > inc > hold.
// Parameters: WIDTH (count width), MODULUS (2 .. 2**WIDTH).
// Ports:
//   clk    in   system clock (falling-edge active)
//   reset  in   async active-high reset
//   bus    slave modport of timing_seq_counter_if (commands in; seq, t, tc,
//          wrap, err out)
// Build option: define SEQ_CONFLICT_CHECK_EN to enable the sticky err flag
// (set on simultaneous commands or a rejected load); otherwise err is 0.
// ---------------------------------------------------------------------------
module timing_seq_counter
    import timing_seq_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input logic                clk,
    input logic                reset,
    timing_seq_counter_if.slave bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("timing_seq_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0]   seq_q;
    logic [WIDTH-1:0]   seq_d;
    logic               wrap_q;
    logic               wrap_d;
    logic [MODULUS-1:0] t_w;
    seq_cmd_e           cmd;

    always_comb begin
        cmd = CMD_HOLD;
        if (bus.clr) begin
            cmd = CMD_CLEAR;
        end else if (bus.ld) begin
            cmd = ({1'b0, bus.ld_val} < MOD_EXT) ? CMD_LOAD : CMD_REJECT;
        end else if (bus.inc) begin
            cmd = (seq_q == LAST) ? CMD_WRAP : CMD_INC;
        end
    end

    // A rejected load falls through the default and holds the count.
    always_comb begin
        seq_d  = seq_q;
        wrap_d = 1'b0;
        case (cmd)
            CMD_CLEAR: seq_d = '0;
            CMD_LOAD:  seq_d = bus.ld_val;
            CMD_WRAP: begin
                seq_d  = '0;
                wrap_d = 1'b1;
            end
            CMD_INC:   seq_d = seq_q + WIDTH'(1);
            default:   seq_d = seq_q;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            seq_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef SEQ_CONFLICT_CHECK_EN
    logic err_q;
    logic conflict;

    assign conflict = (active_count(bus.inc, bus.clr, bus.ld) >= 2'd2)
                    || (cmd == CMD_REJECT);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (conflict) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(negedge clk) begin
        if (!reset && conflict) begin
            $display("timing_seq_counter %m: command conflict inc=%b clr=%b ld=%b ld_val=%0d",
                     bus.inc, bus.clr, bus.ld, bus.ld_val);
        end
    end
`endif

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    seq_onehot_dec #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_dec (
        .seq (seq_q),
        .t   (t_w)
    );

    assign bus.seq  = seq_q;
    assign bus.t    = t_w;
    assign bus.tc   = (seq_q == LAST);
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_timing_seq_counter.sv
// Bench for timing_seq_counter: three instances (16/4, 5/3, 12/4) driven in
// lockstep and compared against an arithmetic model of the counting rules.
module tb_timing_seq_counter;

    logic clk;
    logic reset;

    timing_seq_counter_if #(.WIDTH(4), .MODULUS(16)) b0 ();
    timing_seq_counter_if #(.WIDTH(3), .MODULUS(5))  b1 ();
    timing_seq_counter_if #(.WIDTH(4), .MODULUS(12)) b2 ();

    timing_seq_counter #(.WIDTH(4), .MODULUS(16)) d0 (.clk(clk), .reset(reset), .bus(b0));
    timing_seq_counter #(.WIDTH(3), .MODULUS(5))  d1 (.clk(clk), .reset(reset), .bus(b1));
    timing_seq_counter #(.WIDTH(4), .MODULUS(12)) d2 (.clk(clk), .reset(reset), .bus(b2));

    int total = 0;
    int bad   = 0;

    int modv   [3] = '{16, 5, 12};
    int m_seq  [3];
    int m_wrap [3];
    int m_err  [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic [15:0] seq, input logic [15:0] t,
                            input logic tc, input logic wrap, input logic err);
        chk("seq",  k, seq, 16'(m_seq[k]));
        chk("t",    k, t,   16'(1) << m_seq[k]);
        chk("tc",   k, {15'd0, tc},   16'(m_seq[k] == modv[k] - 1));
        chk("wrap", k, {15'd0, wrap}, 16'(m_wrap[k]));
        chk("err",  k, {15'd0, err},  16'(m_err[k]));
    endtask

    task automatic chk_all();
        chk_inst(0, 16'(b0.seq), 16'(b0.t), b0.tc, b0.wrap, b0.err);
        chk_inst(1, 16'(b1.seq), 16'(b1.t), b1.tc, b1.wrap, b1.err);
        chk_inst(2, 16'(b2.seq), 16'(b2.t), b2.tc, b2.wrap, b2.err);
    endtask

    task automatic drive(input bit i_inc, input bit i_clr, input bit i_ld,
                         input int lv0, input int lv1, input int lv2);
        b0.inc = i_inc; b0.clr = i_clr; b0.ld = i_ld; b0.ld_val = 4'(lv0);
        b1.inc = i_inc; b1.clr = i_clr; b1.ld = i_ld; b1.ld_val = 3'(lv1);
        b2.inc = i_inc; b2.clr = i_clr; b2.ld = i_ld; b2.ld_val = 4'(lv2);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_seq[k]  = 0;
            m_wrap[k] = 0;
            m_err[k]  = 0;
        end
    endtask

    // One falling edge: apply inputs mid-cycle, let the edge happen, advance
    // the model by the stated priority rules, then compare.
    task automatic step(input bit i_inc, input bit i_clr, input bit i_ld,
                        input int lv0, input int lv1, input int lv2);
        int lv [3];
        int n_active;
        @(posedge clk);
        drive(i_inc, i_clr, i_ld, lv0, lv1, lv2);
        lv[0] = lv0 & 15;
        lv[1] = lv1 & 7;
        lv[2] = lv2 & 15;
        n_active = int'(i_inc) + int'(i_clr) + int'(i_ld);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
`ifdef SEQ_CONFLICT_CHECK_EN
            if (n_active >= 2 || (i_ld && lv[k] >= modv[k])) m_err[k] = 1;
`endif
            if (i_clr) begin
                m_seq[k]  = 0;
                m_wrap[k] = 0;
            end else if (i_ld) begin
                if (lv[k] < modv[k]) m_seq[k] = lv[k];
                m_wrap[k] = 0;
            end else if (i_inc) begin
                m_wrap[k] = (m_seq[k] == modv[k] - 1) ? 1 : 0;
                m_seq[k]  = (m_seq[k] + 1) % modv[k];
            end else begin
                m_wrap[k] = 0;
            end
        end
        chk_all();
    endtask

    // Reset raised between edges; outputs must clear before any clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_all();
        @(posedge clk);
        reset = 1'b0;

        // Count up to 5 then reset mid-count (instance 1 also has wrap high).
        repeat (5) step(1, 0, 0, 0, 0, 0);
        reset_mid();

        // Full laps from 0 with inc held: wrap / tc for every modulus.
        repeat (17) step(1, 0, 0, 0, 0, 0);

        // Loads: accepted, then rejected where ld_val >= MODULUS.
        reset_mid();
        step(0, 0, 1, 9, 4, 9);
        step(0, 0, 1, 15, 6, 15);
        step(0, 0, 0, 0, 0, 0);

        // clr + inc together: clear wins, err sticky until reset.
        step(0, 0, 1, 7, 3, 7);
        step(1, 1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);

        // Hold for 10 edges at 3.
        step(0, 0, 1, 3, 3, 3);
        repeat (10) step(0, 0, 0, 0, 0, 0);
        reset_mid();

        // Randomised commands with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_mid();
            end else begin
                step(($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
